// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / scoreboard slice.
package fwd_pkg;

  localparam int REG_AW   = 5;
  localparam int DEF_XLEN = 32;

  typedef logic [REG_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xdata_t;

  // Reason for the current stall. The priority order is load-use, then RAW, then WAW.
  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_LOAD_USE,
    HZ_RAW_LONG,
    HZ_WAW_LONG
  } hazard_e;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID/EX operand bundle. The pipeline side drives it through modport master, and the
// forwarding/scoreboard block uses modport slave.
interface fwd_scoreboard_if
  import fwd_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int REG_NUM = 32
);

  logic [NUM_FWD*REG_AW-1:0] i_fwd_addr;
  logic [NUM_FWD*XLEN-1:0]   i_fwd_data;
  logic [NUM_FWD-1:0]        i_fwd_wr;
  logic [NUM_FWD-1:0]        i_fwd_valid;
  logic [NUM_SRC*REG_AW-1:0] i_src_addr;
  logic [NUM_SRC*XLEN-1:0]   i_src_data;
  logic [NUM_SRC-1:0]        i_src_used;
  logic                      i_issue_valid;
  reg_addr_t                 i_issue_rd;
  logic                      i_issue_long;
  logic                      i_long_done;
  reg_addr_t                 i_long_rd;
  logic [NUM_SRC*XLEN-1:0]   o_src_data;
  logic [NUM_SRC-1:0]        o_fwd_hit;
  logic                      o_stall;
  logic [REG_NUM-1:0]        o_sb_busy;
  logic [31:0]               o_stall_cnt;

  modport master (
    output i_fwd_addr, i_fwd_data, i_fwd_wr, i_fwd_valid,
    output i_src_addr, i_src_data, i_src_used,
    output i_issue_valid, i_issue_rd, i_issue_long, i_long_done, i_long_rd,
    input  o_src_data, o_fwd_hit, o_stall, o_sb_busy, o_stall_cnt
  );

  modport slave (
    input  i_fwd_addr, i_fwd_data, i_fwd_wr, i_fwd_valid,
    input  i_src_addr, i_src_data, i_src_used,
    input  i_issue_valid, i_issue_rd, i_issue_long, i_long_done, i_long_rd,
    output o_src_data, o_fwd_hit, o_stall, o_sb_busy, o_stall_cnt
  );

endinterface

// File: rtl/fwd_src_mux.sv
// Forwarding mux for one source operand. It scans the pipeline stages by priority,
// and stage 0 (the youngest) wins. If the first matching stage is not ready, the mux
// reports not_ready and does not fall through to an older stage.
module fwd_src_mux
  import fwd_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_wr,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  reg_addr_t                 src_addr,
  input  logic [XLEN-1:0]           src_data,
  output logic [XLEN-1:0]           data,
  output logic                      hit,
  output logic                      not_ready
);

  // The loop walks from the oldest stage to the youngest, so the last match written is the youngest one.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    data      = src_data;
    hit       = 1'b0;
    not_ready = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (src_addr != '0 && fwd_wr[k] && fwd_addr[k*REG_AW +: REG_AW] == src_addr) begin
        if (fwd_valid[k]) begin
          data      = fwd_data[k*XLEN +: XLEN];
          hit       = 1'b1;
          not_ready = 1'b0;
        end else begin
          data      = src_data;
          hit       = 1'b0;
          not_ready = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding for the ID/EX stage, plus a scoreboard for long-latency writers.
// The optional stall counter is enabled by defining FWD_STALL_CNT_EN.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int REG_NUM = 32
) (
  input logic             clk,
  input logic             rst_n,
  fwd_scoreboard_if.slave bus
);

  logic [REG_NUM-1:0] sb_q, sb_d;
  logic [XLEN-1:0]    mux_data [NUM_SRC];
  logic               mux_hit  [NUM_SRC];
  logic               mux_nr   [NUM_SRC];
  logic               load_use, raw_long, waw_long, stall;
  hazard_e            hz;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_mux (
      .fwd_addr  (bus.i_fwd_addr),
      .fwd_data  (bus.i_fwd_data),
      .fwd_wr    (bus.i_fwd_wr),
      .fwd_valid (bus.i_fwd_valid),
      .src_addr  (bus.i_src_addr[s*REG_AW +: REG_AW]),
      .src_data  (bus.i_src_data[s*XLEN +: XLEN]),
      .data      (mux_data[s]),
      .hit       (mux_hit[s]),
      .not_ready (mux_nr[s])
    );
  end

  // Classify hazards. A pending long op blocks a read even when a valid forward
  // matches, because the long op is the newer producer of that register.
  always_comb begin
    load_use = 1'b0;
    raw_long = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (bus.i_src_used[s] && mux_nr[s])                                 load_use = 1'b1;
      if (bus.i_src_used[s] && sb_q[bus.i_src_addr[s*REG_AW +: REG_AW]]) raw_long = 1'b1;
    end
    waw_long = bus.i_issue_valid && bus.i_issue_rd != '0 && sb_q[bus.i_issue_rd];
    if (load_use)      hz = HZ_LOAD_USE;
    else if (raw_long) hz = HZ_RAW_LONG;
    else if (waw_long) hz = HZ_WAW_LONG;
    else               hz = HZ_NONE;
    stall = (hz != HZ_NONE);
  end

  // Pack the per-source mux results onto the output bus.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      bus.o_src_data[s*XLEN +: XLEN] = mux_data[s];
      bus.o_fwd_hit[s]               = mux_hit[s];
    end
  end

  // Next scoreboard state. The set is applied after the clear, so a set wins if both hit the same register.
  always_comb begin
    sb_d = sb_q;
    if (bus.i_long_done) sb_d[bus.i_long_rd] = 1'b0;
    if (bus.i_issue_valid && bus.i_issue_long && !stall && bus.i_issue_rd != '0)
      sb_d[bus.i_issue_rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this bit vector is reset on purpose; a stale pending bit would stall forever.
    if (!rst_n) sb_q <= '0;
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    else        sb_q <= sb_d;
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.o_stall_cnt = stall_cnt_q;
`else
  assign bus.o_stall_cnt = 32'd0;
`endif

  assign bus.o_stall   = stall;
  assign bus.o_sb_busy = sb_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed cases followed by a randomised
// run, all compared against a behavioural model kept in the bench.
module tb_fwd_scoreboard;
  import fwd_pkg::*;

  localparam int XLEN = 32;
  localparam int NS   = 2;
  localparam int NF   = 2;
  localparam int RN   = 32;
  localparam int AW   = 5;
`ifdef FWD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.XLEN(XLEN), .NUM_SRC(NS), .NUM_FWD(NF), .REG_NUM(RN)) bus ();

  fwd_scoreboard #(.XLEN(XLEN), .NUM_SRC(NS), .NUM_FWD(NF), .REG_NUM(RN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state: pending long-op destinations, the stall count, and this cycle's expected stall.
  logic [RN-1:0] m_busy;
  logic [31:0]   m_cnt;
  logic          m_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_fwd_addr    = '0;
    bus.i_fwd_data    = '0;
    bus.i_fwd_wr      = '0;
    bus.i_fwd_valid   = '0;
    bus.i_src_addr    = '0;
    bus.i_src_data    = '0;
    bus.i_src_used    = '0;
    bus.i_issue_valid = 1'b0;
    bus.i_issue_rd    = '0;
    bus.i_issue_long  = 1'b0;
    bus.i_long_done   = 1'b0;
    bus.i_long_rd     = '0;
  endtask

  task automatic set_stage(input int k, input logic wr, input logic [AW-1:0] addr,
                           input logic [XLEN-1:0] data, input logic valid);
    bus.i_fwd_wr[k]                = wr;
    bus.i_fwd_addr[k*AW +: AW]     = addr;
    bus.i_fwd_data[k*XLEN +: XLEN] = data;
    bus.i_fwd_valid[k]             = valid;
  endtask

  task automatic set_src(input int s, input logic [AW-1:0] addr, input logic [XLEN-1:0] data,
                         input logic used);
    bus.i_src_addr[s*AW +: AW]     = addr;
    bus.i_src_data[s*XLEN +: XLEN] = data;
    bus.i_src_used[s]              = used;
  endtask

  // Expected combinational outputs: the first matching stage decides, x0 is never forwarded,
  // a pending long op causes a RAW stall, and an issue to a pending rd causes a WAW stall.
  task automatic model_eval(output logic [NS*XLEN-1:0] d, output logic [NS-1:0] h,
                            output logic st);
    logic lu, raw, waw;
    logic [AW-1:0] sa;
    lu = 1'b0; raw = 1'b0; h = '0; d = '0;
    for (int s = 0; s < NS; s++) begin
      sa = bus.i_src_addr[s*AW +: AW];
      d[s*XLEN +: XLEN] = bus.i_src_data[s*XLEN +: XLEN];
      if (sa != 0) begin
        for (int k = 0; k < NF; k++) begin
          if (bus.i_fwd_wr[k] && bus.i_fwd_addr[k*AW +: AW] == sa) begin
            if (bus.i_fwd_valid[k]) begin
              d[s*XLEN +: XLEN] = bus.i_fwd_data[k*XLEN +: XLEN];
              h[s] = 1'b1;
            end else if (bus.i_src_used[s]) begin
              lu = 1'b1;
            end
            break;
          end
        end
      end
      if (bus.i_src_used[s] && m_busy[sa]) raw = 1'b1;
    end
    waw = bus.i_issue_valid && bus.i_issue_rd != 0 && m_busy[bus.i_issue_rd];
    st  = lu | raw | waw;
  endtask

  // Sample the DUT mid-cycle and compare every output against the model.
  task automatic sample();
    logic [NS*XLEN-1:0] ed;
    logic [NS-1:0]      eh;
    logic               es;
    @(negedge clk);
    model_eval(ed, eh, es);
    m_stall = es;
    check("src_data",  64'(bus.o_src_data),  64'(ed));
    check("fwd_hit",   64'(bus.o_fwd_hit),   64'(eh));
    check("stall",     64'(bus.o_stall),     64'(es));
    check("sb_busy",   64'(bus.o_sb_busy),   64'(m_busy));
    check("stall_cnt", 64'(bus.o_stall_cnt), 64'(m_cnt));
  endtask

  // Apply the clock-edge rules to the model, then move just past the next rising edge.
  task automatic advance();
    if (CNT_EN && m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (bus.i_long_done && bus.i_long_rd != 0) m_busy[bus.i_long_rd] = 1'b0;
    if (bus.i_issue_valid && bus.i_issue_long && !m_stall && bus.i_issue_rd != 0)
      m_busy[bus.i_issue_rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic issue_long(input logic [AW-1:0] rd);
    clear_inputs();
    bus.i_issue_valid = 1'b1;
    bus.i_issue_rd    = rd;
    bus.i_issue_long  = 1'b1;
    cycle();
    clear_inputs();
  endtask

  initial begin
    m_busy = '0;
    m_cnt = '0;
    m_stall = 1'b0;
    clear_inputs();

    // Power-on reset, asserted asynchronously.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_sb",    64'(bus.o_sb_busy),   64'd0);
    check("rst_cnt",   64'(bus.o_stall_cnt), 64'd0);
    check("rst_stall", 64'(bus.o_stall),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Long-op RAW: issue at T, sb from T+1, dependent stalls T+2..T+8, done at T+8.
    issue_long(5'd9);
    sample();
    check("raw_sb9_set", 64'(bus.o_sb_busy[9]), 64'd1);
    advance();
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      set_src(0, 5'd9, 32'h1234_5678, 1'b1);
      if (i == 6) begin
        bus.i_long_done = 1'b1;
        bus.i_long_rd   = 5'd9;
      end
      sample();
      check("raw_stall", 64'(bus.o_stall), 64'd1);
      advance();
    end
    clear_inputs();
    set_src(0, 5'd9, 32'h0DD0_0009, 1'b1);
    sample();
    check("raw_release",  64'(bus.o_stall),            64'd0);
    check("raw_sb9_clr",  64'(bus.o_sb_busy[9]),       64'd0);
    check("raw_new_data", 64'(bus.o_src_data[31:0]),   64'h0DD0_0009);
    check("raw_cnt",      64'(bus.o_stall_cnt),        CNT_EN ? 64'd7 : 64'd0);
    advance();

    // Forwarding priority: the youngest matching stage wins.
    clear_inputs();
    set_stage(0, 1'b1, 5'd5, 32'hAAAA_0001, 1'b1);
    set_stage(1, 1'b1, 5'd5, 32'hBBBB_0002, 1'b1);
    set_src(0, 5'd5, 32'h1111_1111, 1'b1);
    sample();
    check("prio_data",  64'(bus.o_src_data[31:0]), 64'hAAAA_0001);
    check("prio_hit",   64'(bus.o_fwd_hit[0]),     64'd1);
    check("prio_stall", 64'(bus.o_stall),          64'd0);
    advance();

    // x0 is never forwarded.
    set_stage(0, 1'b1, 5'd0, 32'hAAAA_0001, 1'b1);
    set_stage(1, 1'b1, 5'd0, 32'hBBBB_0002, 1'b1);
    set_src(0, 5'd0, 32'h0F0F_0F0F, 1'b1);
    sample();
    check("x0_data", 64'(bus.o_src_data[31:0]), 64'h0F0F_0F0F);
    check("x0_hit",  64'(bus.o_fwd_hit[0]),     64'd0);
    advance();

    // Load-use: a not-ready youngest match stalls and does not fall through to stage 1.
    clear_inputs();
    set_stage(0, 1'b1, 5'd7, 32'hCCCC_0003, 1'b0);
    set_stage(1, 1'b1, 5'd7, 32'hDDDD_0004, 1'b1);
    set_src(1, 5'd7, 32'h2222_2222, 1'b1);
    sample();
    check("lu_stall", 64'(bus.o_stall),           64'd1);
    check("lu_hit",   64'(bus.o_fwd_hit[1]),      64'd0);
    check("lu_data",  64'(bus.o_src_data[63:32]), 64'h2222_2222);
    advance();
    bus.i_src_used[1] = 1'b0;
    sample();
    check("lu_unused_stall", 64'(bus.o_stall), 64'd0);
    advance();

    // WAW: an issue to a pending rd stalls and leaves the scoreboard unchanged.
    issue_long(5'd3);
    bus.i_issue_valid = 1'b1;
    bus.i_issue_rd    = 5'd3;
    bus.i_issue_long  = 1'b1;
    sample();
    check("waw_stall", 64'(bus.o_stall), 64'd1);
    advance();
    clear_inputs();
    sample();
    check("waw_sb", 64'(bus.o_sb_busy), 64'h0000_0008);
    advance();
    // Clear rd 3, then apply a clear and a non-stalled set to rd 3 in the same cycle.
    bus.i_long_done = 1'b1;
    bus.i_long_rd   = 5'd3;
    cycle();
    bus.i_issue_valid = 1'b1;
    bus.i_issue_rd    = 5'd3;
    bus.i_issue_long  = 1'b1;
    sample();
    check("coll_no_stall", 64'(bus.o_stall), 64'd0);
    advance();
    clear_inputs();
    sample();
    check("coll_set_wins", 64'(bus.o_sb_busy[3]), 64'd1);
    advance();
    // A clear of x0 changes nothing.
    bus.i_long_done = 1'b1;
    bus.i_long_rd   = 5'd0;
    cycle();
    clear_inputs();

    // Randomised traffic over a small register window so hits and hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NF; k++)
        set_stage(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 3) != 0));
      for (int s = 0; s < NS; s++)
        set_src(s, AW'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
      bus.i_issue_valid = 1'($urandom_range(0, 1));
      bus.i_issue_rd    = AW'($urandom_range(0, 7));
      bus.i_issue_long  = 1'($urandom_range(0, 2) == 0);
      bus.i_long_done   = 1'($urandom_range(0, 3) == 0);
      bus.i_long_rd     = AW'($urandom_range(0, 7));
      cycle();
    end
    clear_inputs();

    // Reset mid-operation: start clean, build sb[4], sb[12] and a count of 20, then reset asynchronously.
    #1 rst_n = 1'b0;
    m_busy = '0;
    m_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue_long(5'd4);
    issue_long(5'd12);
    for (int i = 0; i < 20; i++) begin
      set_src(0, 5'd4, 32'h4444_4444, 1'b1);
      cycle();
    end
    check("pre_rst_cnt", 64'(bus.o_stall_cnt), CNT_EN ? 64'd20 : 64'd0);
    check("pre_rst_sb",  64'(bus.o_sb_busy),   64'h0000_1010);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_sb",    64'(bus.o_sb_busy),   64'd0);
    check("mid_rst_cnt",   64'(bus.o_stall_cnt), 64'd0);
    check("mid_rst_stall", 64'(bus.o_stall),     64'd0);
    m_busy = '0;
    m_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the two-stage rs1/rs2 forwarding mux.
- Forwards from NUM_FWD pipeline stages to NUM_SRC source operands.
- Adds a registered scoreboard for long-latency writers, such as the divider or a load miss.
- Raises a stall for three cases: load-use, a pending long-op RAW, and WAW against a pending long op.
- Sits in ID/EX between the regfile read ports and the ALU operand muxes.

Parameters:
- XLEN, 32: data width.
- NUM_SRC, 2: number of source operands forwarded.
- NUM_FWD, 2: number of forwarding stages. Index 0 is the youngest (EX/MEM); higher indices are older (MEM/WB, ...).
- REG_NUM, 32: architectural register count. Address width is $clog2(REG_NUM).

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- i_fwd_addr, input, NUM_FWD*5: rd address per stage.
- i_fwd_data, input, NUM_FWD*XLEN: rd data per stage.
- i_fwd_wr, input, NUM_FWD: stage will write rd.
- i_fwd_valid, input, NUM_FWD: stage data is final. 0 means the load result is not yet available.
- i_src_addr, input, NUM_SRC*5: source register addresses.
- i_src_data, input, NUM_SRC*XLEN: regfile read data.
- i_src_used, input, NUM_SRC: instruction actually reads this source.
- i_issue_valid, input, 1: an instruction leaves ID this cycle.
- i_issue_rd, input, 5: destination of the issuing instruction.
- i_issue_long, input, 1: the issuing instruction is a long-latency writer.
- i_long_done, input, 1: a long op writes the regfile at this clock edge.
- i_long_rd, input, 5: destination of the completing long op.
- o_src_data, output, NUM_SRC*XLEN: forwarded operands.
- o_fwd_hit, output, NUM_SRC: operand taken from a forwarding stage.
- o_stall, output, 1: hold ID and inject a bubble.
- o_sb_busy, output, REG_NUM: scoreboard bit vector.
- o_stall_cnt, output, 32: stall statistic (see Optional Feature).

Behaviour:
- Reset: sb all zeros, o_stall_cnt=0. Combinational outputs follow the inputs, so o_stall=0 with an empty sb and no fwd hazards.
- Forwarding, per source s (combinational, zero latency):
  - Scan stages k=0..NUM_FWD-1 and take the first k with i_fwd_wr[k], i_fwd_addr[k]==i_src_addr[s], and i_src_addr[s]!=0.
  - If that k has i_fwd_valid[k]=1: o_src_data[s] = i_fwd_data[k] and o_fwd_hit[s]=1.
  - If that k has i_fwd_valid[k]=0: load-use hazard. Raise the stall and do NOT fall through to older stages.
  - No match: o_src_data[s] = i_src_data[s] and o_fwd_hit[s]=0.
  - x0 is never forwarded and never busy.
- RAW stall: any s with i_src_used[s] and sb[i_src_addr[s]]=1.
  - A matching valid forward does not override it; the long op is the newer producer.
- WAW stall: i_issue_valid && i_issue_rd!=0 && sb[i_issue_rd]=1.
- o_stall = load-use OR RAW OR WAW. Load-use only counts for sources with i_src_used=1.
- Scoreboard update, at the clock edge:
  - Set: sb[i_issue_rd] is set when i_issue_valid && i_issue_long && !o_stall && i_issue_rd!=0.
  - Clear: sb[i_long_rd] is cleared when i_long_done.
  - Same register set and cleared in one cycle: set wins.
  - Clear of rd 0, or of a non-busy register, is a no-op.
- Timing:
  - The clear is visible in the cycle after i_long_done, so the stall drops one cycle after done.
  - The regfile was written at that same edge, so the read in the released cycle returns the new value.
- Issue gating: i_issue_valid is ignored for sb update while o_stall=1. The upstream logic must hold the instruction in that case.
- Reset mid-operation clears all pending bits. Pipeline flush is the owner's responsibility.

Optional Feature:
- Macro FWD_STALL_CNT_EN.
- When defined: o_stall_cnt increments by 1 every cycle o_stall=1, saturates at 32'hFFFF_FFFF, and resets to 0.
- When undefined: no counter register; o_stall_cnt is tied to 0.

Decomposition:
- Package fwd_pkg holds:
  - localparam REG_AW=5;
  - typedef logic [REG_AW-1:0] reg_addr_t;
  - typedef logic [XLEN-1:0] xdata_t with XLEN=32 default;
  - the enum hazard_e {HZ_NONE, HZ_LOAD_USE, HZ_RAW_LONG, HZ_WAW_LONG}, used for debug visibility.
- Sub-module fwd_src_mux: a single-source priority scan over NUM_FWD stages. It returns data, hit and not_ready, and is instantiated NUM_SRC times via generate.

Test Plan:
- Basic forwarding priority:
  - Stimulus: src0=5, stage0 {wr=1, addr=5, data=0xAAAA_0001, valid=1}, stage1 {addr=5, data=0xBBBB_0002}.
  - Required: o_src_data[0]=0xAAAA_0001, hit=1, stall=0.
  - Repeat with src addr=0: regfile data passes through and hit=0.
- Load-use:
  - Stimulus: stage0 {addr=7, wr=1, valid=0}, stage1 {addr=7, valid=1}, src1=7 used.
  - Required: o_stall=1 (no fall-through).
  - Same case with i_src_used[1]=0: o_stall=0.
- Long-op RAW:
  - Issue long rd=9 at cycle T; sb[9]=1 from T+1.
  - Source 9 stalls until i_long_done rd=9 at cycle T+8; o_stall=0 at T+9.
  - With FWD_STALL_CNT_EN: o_stall_cnt=7 covering T+2..T+8, i.e. the dependent is presented from T+2.
- WAW plus set/clear collision:
  - sb[3]=1; issue rd=3 → stall, sb unchanged.
  - Later, in the same cycle: i_long_done rd=3 and a non-stalled long issue rd=3 → sb[3] stays 1.
- Reset mid-operation:
  - sb[4]=1, sb[12]=1, counter=20; assert rst_n=0 asynchronously mid-cycle.
  - Required: o_sb_busy=0, o_stall_cnt=0, and o_stall drops immediately.
